// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int MAX_WORDS  = (2 ** ADDR_WIDTH) / 4;
  localparam int CSUM_WIDTH = 8;
  // one extra bit so the word counter can reach MAX_WORDS without wrapping
  localparam int WCNT_WIDTH = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the loader
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - packs four stream bytes LSB-first into a 32-bit word
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] lanes;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane  <= 2'd0;
      lanes <= 24'd0;
    end else if (byte_valid) begin
      case (lane)
        2'd0:    lanes[7:0]   <= byte_in;
        2'd1:    lanes[15:8]  <= byte_in;
        2'd2:    lanes[23:16] <= byte_in;
        default: ;
      endcase
      lane <= lane + 2'd1;
    end
  end

  // the 4th byte is merged combinationally so the word is complete on its transfer edge
  assign word       = {byte_in, lanes};
  assign word_valid = byte_valid && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a checksummed byte stream into instruction memory
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  state_t                state, state_next;
  logic                  xfer, enter_len, byte_valid, word_valid, len_ok, last_word;
  logic [31:0]           word;
  logic [WCNT_WIDTH-1:0] len, word_cnt;
  logic [CSUM_WIDTH-1:0] csum;

  assign xfer       = bus.in_valid && bus.in_ready;
  assign enter_len  = start && (state == IDLE || state == DONE || state == ERR);
  assign byte_valid = xfer && (state == DATA);
  assign len_ok     = (bus.in_data != 8'd0) && (int'(bus.in_data) <= MAX_WORDS);
  assign last_word  = (word_cnt == len - WCNT_WIDTH'(1));

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (enter_len),
    .byte_valid (byte_valid),
    .byte_in    (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN;
      LEN:             if (xfer) state_next = len_ok ? DATA : ERR;
      DATA:            if (word_valid && last_word) state_next = CSUM;
      CSUM:            if (xfer) state_next = (bus.in_data == csum) ? DONE : ERR;
      default:         state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    cpu_reset    = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      LEN, DATA, CSUM: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len           <= '0;
      word_cnt      <= '0;
      csum          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'd0;
    end else begin
      bus.mem_we <= 1'b0;
      if (enter_len) begin
        word_cnt <= '0;
        csum     <= '0;
      end
      if (state == LEN && xfer) len <= bus.in_data[WCNT_WIDTH-1:0];
      if (byte_valid) csum <= csum + bus.in_data;
      if (word_valid) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= {word_cnt[ADDR_WIDTH-3:0], 2'b00};
        bus.mem_wdata <= word;
        word_cnt      <= word_cnt + WCNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized loads checked against a stream-level model
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset, start;
  logic cpu_reset, busy, done, error;
  int   passed = 0, total = 0, fails = 0;

  logic [31:0] words[$];
  logic [39:0] obs_q[$];

  imem_loader_if bus ();

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.mem_we) obs_q.push_back({bus.mem_addr, bus.mem_wdata});

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int gap_of(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(3, 0));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      fails++;
      $error("FAIL in_ready_wait observed=0 expected=1");
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk(tag, {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_reset, busy, done, error},
        {2'b00, 8'h00, 32'h0, 4'b1000});
  endtask

  // csum_mode: -1 correct sum, -2 corrupted sum, otherwise the literal checksum byte
  task automatic load(input int len, input int csum_mode, input int gmode, input bit mid_start);
    logic [7:0] sum, b, c;
    bit len_ok, good;
    int nexp;
    sum    = 8'd0;
    len_ok = (len >= 1 && len <= 64);
    obs_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("after_start", {bus.in_ready, cpu_reset, busy, done, error}, 5'b11100);
    send_byte(len[7:0], gap_of(gmode));
    if (len_ok) begin
      for (int w = 0; w < len; w++) begin
        for (int k = 0; k < 4; k++) begin
          b = words[w][8*k +: 8];
          sum = sum + b;
          if (mid_start && w == 1 && k == 1) start = 1'b1;
          send_byte(b, gap_of(gmode));
          start = 1'b0;
        end
      end
      if (csum_mode == -1)      c = sum;
      else if (csum_mode == -2) c = sum ^ 8'h5a;
      else                      c = csum_mode[7:0];
      send_byte(c, gap_of(gmode));
      good = (c == sum);
    end else begin
      good = 1'b0;
    end
    chk("final_status", {bus.in_ready, cpu_reset, busy, done, error}, good ? 5'b00010 : 5'b01001);
    nexp = len_ok ? len : 0;
    chk("write_count", 64'(obs_q.size()), 64'(nexp));
    for (int i = 0; i < obs_q.size() && i < nexp; i++)
      chk("write", obs_q[i], {8'(4 * i), words[i]});
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset_state");
    reset = 1'b0;
    @(negedge clk);

    words = '{32'h00000013};
    load(1, 8'h13, 0, 1'b0);

    words = '{32'h00100093, 32'h00200113};
    load(2, 8'hd9, 1, 1'b0);
    load(2, 8'h00, 0, 1'b0);
    load(2, -1, 2, 1'b0);

    load(0, -1, 0, 1'b0);
    load(65, -1, 0, 1'b0);

    words.delete();
    for (int i = 0; i < 64; i++) words.push_back(32'hffffffff);
    load(64, 8'h00, 0, 1'b0);

    words = '{32'h11223344, 32'h55667788, 32'h99aabbcc};
    load(3, -1, 0, 1'b1);

    obs_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd3, 0);
    send_byte(words[0][7:0], 0);
    send_byte(words[0][15:8], 0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("reset_mid_load");
    chk("reset_mid_writes", 64'(obs_q.size()), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(8, 1));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      load(n, ($urandom_range(2, 0) == 0) ? -2 : -1, 2, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
